operand_encoder: RTL and testbench

Sequential inverse of the operand handler. Given a target operand value, a select code and the register operand, it produces the 21-bit immediate field `I` that makes the operand handler reproduce the target. It also reports whether such an encoding exists. The assembler/self-test path uses it to build immediates for the ALU operand path. Immediate forms resolve in one cycle; shift forms use an iterative search over shift amounts.

---
 rtl/operand_encoder.sv | 145 ++++++++++++++
 tb/tb_operand_encoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/operand_encoder.sv
// Inverse of the operand handler: finds the 21-bit immediate that reproduces a
// target operand for a given select code, using an iterative search for the shift forms.
module operand_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  sel,
  input  logic [31:0] rb,
  input  logic [31:0] target,
  output logic        busy,
  output logic        done,
  output logic [20:0] i_out,
  output logic        fit
);

  typedef enum logic [1:0] {IDLE, EVAL, SEARCH, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] rb_q, rb_d;
  logic [31:0] v_q, v_d;
  logic [4:0]  k_q, k_d;
  logic        res_fit_q, res_fit_d;
  logic [20:0] res_i_q, res_i_d;
  logic        fit_q, fit_d;
  logic [20:0] i_out_q, i_out_d;
  logic        done_q, done_d;

  logic [31:0] cand;
  logic        ev_fit;
  logic [20:0] ev_i;

  always_comb begin
    case (sel_q)
      3'b100:  cand = rb_q >> k_q;
      3'b101:  cand = $signed(rb_q) >>> k_q;
      default: cand = rb_q << k_q;
    endcase
  end

  always_comb begin
    ev_fit = 1'b0;
    ev_i   = '0;
    case (sel_q)
      3'b000: ev_fit = (v_q == rb_q);
      3'b001: begin
        ev_fit = (v_q[31:10] == '0) || (v_q[31:10] == '1);
        ev_i   = {10'b0, v_q[9:0], v_q[31]};
      end
      3'b010: begin
        ev_fit = (v_q[31:13] == '0) || (v_q[31:13] == '1);
        ev_i   = {7'b0, v_q[12:0], v_q[31]};
      end
      3'b011: begin
        ev_fit = (v_q[10:0] == '0);
        ev_i   = v_q[31:11];
      end
      default: ev_fit = (v_q == '0);
    endcase
    if (!ev_fit) ev_i = '0;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rb_d      = rb_q;
    v_d       = v_q;
    k_d       = k_q;
    res_fit_d = res_fit_q;
    res_i_d   = res_i_q;
    fit_d     = fit_q;
    i_out_d   = i_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d = sel;
          rb_d  = rb;
          v_d   = target;
          k_d   = '0;
          if (sel == 3'b100 || sel == 3'b101 || sel == 3'b110) state_d = SEARCH;
          else                                                 state_d = EVAL;
        end
      end
      EVAL: begin
        res_fit_d = ev_fit;
        res_i_d   = ev_i;
        state_d   = DONE;
      end
      SEARCH: begin
        if (cand == v_q) begin
          res_fit_d = 1'b1;
          res_i_d   = {11'b0, 5'(5'd31 - k_q), 5'b0};
          state_d   = DONE;
        end else if (k_q == 5'd31) begin
          res_fit_d = 1'b0;
          res_i_d   = '0;
          state_d   = DONE;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      DONE: begin
        // Published results change only on the edge that raises done.
        done_d  = 1'b1;
        fit_d   = res_fit_q;
        i_out_d = res_i_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rb_q      <= '0;
      v_q       <= '0;
      k_q       <= '0;
      res_fit_q <= 1'b0;
      res_i_q   <= '0;
      fit_q     <= 1'b0;
      i_out_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rb_q      <= rb_d;
      v_q       <= v_d;
      k_q       <= k_d;
      res_fit_q <= res_fit_d;
      res_i_q   <= res_i_d;
      fit_q     <= fit_d;
      i_out_q   <= i_out_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign fit   = fit_q;
  assign i_out = i_out_q;

endmodule

// File: tb/tb_operand_encoder.sv
// Directed-vector bench for operand_encoder: latency, encodings, start
// filtering and asynchronous abort.
module tb_operand_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] rb = '0;
  logic [31:0] target = '0;
  logic        busy, done, fit;
  logic [20:0] i_out;

  int n_checks = 0;
  int n_fail = 0;

  operand_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .rb(rb),
    .target(target), .busy(busy), .done(done), .i_out(i_out), .fit(fit)
  );

  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for done; lat = -1 on timeout.
  task automatic run_req(input logic [2:0] s, input logic [31:0] r, input logic [31:0] t,
                         output int lat, output logic f, output logic [20:0] i,
                         output logic b_start, output logic b_done);
    @(negedge clk);
    sel = s; rb = r; target = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sel = 3'b000; rb = 32'hDEAD_BEEF; target = 32'h5A5A_5A5A;
    b_start = busy;
    lat = -1; f = 1'bx; i = 'x; b_done = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; f = fit; i = i_out; b_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({busy, done, fit, i_out} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b fit=%b i_out=%h, need all 0", busy, done, fit, i_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic check_req(input string name, input logic [2:0] s, input logic [31:0] r,
                           input logic [31:0] t, input int exp_lat, input logic exp_f,
                           input logic [20:0] exp_i);
    int lat; logic f; logic [20:0] i; logic bs, bd;
    run_req(s, r, t, lat, f, i, bs, bd);
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d need %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (f !== exp_f) begin
      n_fail++; $display("FAIL %s_fit: got %b need %b", name, f, exp_f);
    end
    n_checks++;
    if (i !== exp_i) begin
      n_fail++; $display("FAIL %s_i_out: got %h need %h", name, i, exp_i);
    end
    n_checks++;
    if (bs !== 1'b1 || bd !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got start=%b done=%b need 1/0", name, bs, bd);
    end
  endtask

  task automatic test_immediate;
    check_req("imm001_fit",   3'b001, 32'h0, 32'hFFFF_FC00, 2, 1'b1, 21'h000001);
    check_req("imm001_nofit", 3'b001, 32'h0, 32'h0000_0400, 2, 1'b0, 21'h0);
    check_req("imm010_fit",   3'b010, 32'h0, 32'h0000_1ABC, 2, 1'b1, 21'h003578);
    check_req("imm011_fit",   3'b011, 32'h0, 32'h1234_5800, 2, 1'b1, 21'h02468B);
    check_req("imm011_nofit", 3'b011, 32'h0, 32'h1234_5801, 2, 1'b0, 21'h0);
    check_req("imm000_fit",   3'b000, 32'hCAFE_0001, 32'hCAFE_0001, 2, 1'b1, 21'h0);
    check_req("imm111_nofit", 3'b111, 32'h0, 32'h0000_0001, 2, 1'b0, 21'h0);
  endtask

  task automatic test_search;
    check_req("lsr_k15", 3'b100, 32'h8000_0000, 32'h0001_0000, 17, 1'b1, 21'h00200);
    check_req("asr_k15", 3'b101, 32'h8000_0000, 32'hFFFF_0000, 17, 1'b1, 21'h00200);
    check_req("lsl_k0",  3'b110, 32'h0000_0003, 32'h0000_0003, 2,  1'b1, 21'h003E0);
    check_req("lsl_k31", 3'b110, 32'h0000_0001, 32'h8000_0000, 33, 1'b1, 21'h00000);
    check_req("lsl_none",3'b110, 32'h0000_0001, 32'h0000_0003, 33, 1'b0, 21'h0);
  endtask

  task automatic test_ignore_start;
    int lat = -1;
    @(negedge clk);
    sel = 3'b100; rb = 32'h8000_0000; target = 32'h0001_0000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin sel = 3'b000; rb = 32'h0; target = 32'h0; start = 1'b1; end
      if (c == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    n_checks++;
    if (lat != 17 || fit !== 1'b1 || i_out !== 21'h00200) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d fit=%b i_out=%h need 17/1/00200", lat, fit, i_out);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_start_idle: got busy=%b need 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat1 = -1, lat2 = -1;
    @(negedge clk);
    sel = 3'b011; target = 32'h0000_0800; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = c; break; end
    end
    n_checks++;
    if (lat1 != 2 || fit !== 1'b1 || i_out !== 21'h000001) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d fit=%b i_out=%h need 2/1/000001", lat1, fit, i_out);
    end
    sel = 3'b100; rb = 32'h0000_00F0; target = 32'h0000_000F; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b need 1", busy);
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = c; break; end
    end
    n_checks++;
    if (lat2 != 6 || fit !== 1'b1 || i_out !== 21'h00360) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d fit=%b i_out=%h need 6/1/00360", lat2, fit, i_out);
    end
  endtask

  task automatic test_abort;
    int done_seen = 0;
    @(negedge clk);
    sel = 3'b101; rb = 32'h0000_0001; target = 32'h7777_7777; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    n_checks++;
    if ({busy, done, fit, i_out} !== 24'h0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b done=%b fit=%b i_out=%h need all 0", busy, done, fit, i_out);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: got done_count=%0d busy=%b need 0/0", done_seen, busy);
    end
    check_req("post_abort", 3'b001, 32'h0, 32'h0000_0155, 2, 1'b1, 21'h0002AA);
  endtask

  initial begin
    test_reset;
    test_immediate;
    test_search;
    test_ignore_start;
    test_back_to_back;
    check_req("pre_abort", 3'b100, 32'h8000_0000, 32'h0001_0000, 17, 1'b1, 21'h00200);
    test_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
